mem_access_stage: RTL and testbench

//  Parametrised MEM->WB stage of the pipelined RISC-V core. Drives the data-memory
//  req/ack port and generates store byte-enables. Sign/zero-extends load data and

---
 rtl/mem_access_stage.sv | 200 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM->WB stage: data-memory req/ack port, store byte-enables, load extension, WB register. Optional MEM_MISALIGN_TRAP_EN.
// Latency: non-memory ops 1 cycle; memory ops accept edge + k BUSY cycles, result visible the cycle after ack.
// Backpressure: stall_out is high every BUSY cycle; hold freezes only in IDLE, and an issued access always completes.
module mem_access_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5,
    parameter int BE_W = XLEN / 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_alu_res,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [XLEN-1:0] ex_pc_plus_4,
    input  logic [RA_W-1:0] ex_rd,
    input  logic [2:0]      ex_funct3,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic            ex_reg_write,
    input  logic [1:0]      ex_result_src,
    input  logic            hold,
    input  logic            flush,
    output logic            stall_out,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [BE_W-1:0] dmem_be,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ack,
    output logic            wb_valid,
    output logic            wb_reg_write,
    output logic [1:0]      wb_result_src,
    output logic [RA_W-1:0] wb_rd,
    output logic [XLEN-1:0] wb_alu_res,
    output logic [XLEN-1:0] wb_read_data,
    output logic [XLEN-1:0] wb_pc_plus_4,
    output logic            wb_exc
);
    localparam int OFF_W = $clog2(BE_W);
    localparam logic [1:0] FULL_SIZE = (XLEN == 64) ? 2'd3 : 2'd2;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state;

    logic [1:0]      lat_size;
    logic [OFF_W-1:0] lat_off;
    logic            lat_unsigned;
    logic            lat_read;
    logic [RA_W-1:0] lat_rd;
    logic            lat_reg_write;
    logic [1:0]      lat_result_src;
    logic [XLEN-1:0] lat_alu_res;
    logic [XLEN-1:0] lat_pc_plus_4;

    // Access size as log2(bytes); sizes the datapath cannot hold fall back to full width.
    logic [1:0]       ex_size;
    logic [OFF_W-1:0] ex_off, low_mask, al_off, off_ones;
    logic [BE_W-1:0]  be_all, be_base, ex_be;
    logic [XLEN-1:0]  ex_wdata, al_addr;
    logic             misaligned, trap, mem_op;

    always_comb begin
        case (ex_funct3[1:0])
            2'b00:   ex_size = 2'd0;
            2'b01:   ex_size = 2'd1;
            2'b10:   ex_size = 2'd2;
            default: ex_size = FULL_SIZE;
        endcase
        off_ones   = '1;
        be_all     = '1;
        ex_off     = ex_alu_res[OFF_W-1:0];
        low_mask   = ~(off_ones << ex_size);
        misaligned = |(ex_off & low_mask);
        al_off     = ex_off & ~low_mask;
        al_addr    = {ex_alu_res[XLEN-1:OFF_W], al_off};
        be_base    = ~(be_all << (32'd1 << ex_size));
        ex_be      = be_base << al_off;
        case (ex_size)
            2'd0:    ex_wdata = {BE_W{ex_store_data[7:0]}};
            2'd1:    ex_wdata = {(BE_W/2){ex_store_data[15:0]}};
            2'd2:    ex_wdata = {(XLEN/32){ex_store_data[31:0]}};
            default: ex_wdata = ex_store_data;
        endcase
        mem_op = ex_valid && !flush && (ex_mem_read || ex_mem_write);
        trap   = TRAP_EN && misaligned;
    end

    logic [XLEN-1:0] rd_shifted, rd_ext;

    always_comb begin
        rd_shifted = dmem_rdata >> {lat_off, 3'b000};
        case (lat_size)
            2'd0:    rd_ext = lat_unsigned ? XLEN'(rd_shifted[7:0])  : XLEN'($signed(rd_shifted[7:0]));
            2'd1:    rd_ext = lat_unsigned ? XLEN'(rd_shifted[15:0]) : XLEN'($signed(rd_shifted[15:0]));
            2'd2:    rd_ext = lat_unsigned ? XLEN'(rd_shifted[31:0]) : XLEN'($signed(rd_shifted[31:0]));
            default: rd_ext = rd_shifted;
        endcase
    end

    assign stall_out = (state == BUSY);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            dmem_be        <= '0;
            lat_size       <= '0;
            lat_off        <= '0;
            lat_unsigned   <= 1'b0;
            lat_read       <= 1'b0;
            lat_rd         <= '0;
            lat_reg_write  <= 1'b0;
            lat_result_src <= '0;
            lat_alu_res    <= '0;
            lat_pc_plus_4  <= '0;
            wb_valid       <= 1'b0;
            wb_reg_write   <= 1'b0;
            wb_result_src  <= '0;
            wb_rd          <= '0;
            wb_alu_res     <= '0;
            wb_read_data   <= '0;
            wb_pc_plus_4   <= '0;
            wb_exc         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!hold) begin
                        if (mem_op && trap) begin
                            wb_valid      <= 1'b1;
                            wb_exc        <= 1'b1;
                            wb_reg_write  <= 1'b0;
                            wb_result_src <= ex_result_src;
                            wb_rd         <= ex_rd;
                            wb_alu_res    <= ex_alu_res;
                            wb_read_data  <= '0;
                            wb_pc_plus_4  <= ex_pc_plus_4;
                        end else if (mem_op) begin
                            state          <= BUSY;
                            dmem_req       <= 1'b1;
                            dmem_we        <= ex_mem_write;
                            dmem_addr      <= al_addr;
                            dmem_wdata     <= ex_wdata;
                            dmem_be        <= ex_be;
                            lat_size       <= ex_size;
                            lat_off        <= al_off;
                            lat_unsigned   <= ex_funct3[2];
                            lat_read       <= ex_mem_read;
                            lat_rd         <= ex_rd;
                            lat_reg_write  <= ex_reg_write;
                            lat_result_src <= ex_result_src;
                            lat_alu_res    <= ex_alu_res;
                            lat_pc_plus_4  <= ex_pc_plus_4;
                            wb_valid       <= 1'b0;
                            wb_reg_write   <= 1'b0;
                            wb_exc         <= 1'b0;
                        end else if (ex_valid && !flush) begin
                            wb_valid      <= 1'b1;
                            wb_exc        <= 1'b0;
                            wb_reg_write  <= ex_reg_write;
                            wb_result_src <= ex_result_src;
                            wb_rd         <= ex_rd;
                            wb_alu_res    <= ex_alu_res;
                            wb_read_data  <= '0;
                            wb_pc_plus_4  <= ex_pc_plus_4;
                        end else begin
                            wb_valid     <= 1'b0;
                            wb_reg_write <= 1'b0;
                            wb_exc       <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        state         <= IDLE;
                        dmem_req      <= 1'b0;
                        dmem_we       <= 1'b0;
                        wb_valid      <= 1'b1;
                        wb_exc        <= 1'b0;
                        wb_reg_write  <= lat_reg_write;
                        wb_result_src <= lat_result_src;
                        wb_rd         <= lat_rd;
                        wb_alu_res    <= lat_alu_res;
                        wb_read_data  <= lat_read ? rd_ext : '0;
                        wb_pc_plus_4  <= lat_pc_plus_4;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage (XLEN=32): directed cases plus randomized ops vs a byte-level model.
module tb_mem_access_stage;
    localparam int XLEN = 32;
    localparam int RA_W = 5;
    localparam int BE_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, hold, flush;
    logic [XLEN-1:0] ex_alu_res, ex_store_data, ex_pc_plus_4, dmem_rdata;
    logic [RA_W-1:0] ex_rd;
    logic [2:0] ex_funct3;
    logic [1:0] ex_result_src;
    logic dmem_ack;
    logic stall_out, dmem_req, dmem_we, wb_valid, wb_reg_write, wb_exc;
    logic [XLEN-1:0] dmem_addr, dmem_wdata, wb_alu_res, wb_read_data, wb_pc_plus_4;
    logic [BE_W-1:0] dmem_be;
    logic [1:0] wb_result_src;
    logic [RA_W-1:0] wb_rd;

    mem_access_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_alu_res(ex_alu_res),
        .ex_store_data(ex_store_data), .ex_pc_plus_4(ex_pc_plus_4), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_result_src(ex_result_src), .hold(hold), .flush(flush),
        .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_result_src(wb_result_src),
        .wb_rd(wb_rd), .wb_alu_res(wb_alu_res), .wb_read_data(wb_read_data),
        .wb_pc_plus_4(wb_pc_plus_4), .wb_exc(wb_exc)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    // Pick sz bytes starting at byte off, then sign- or zero-extend arithmetically.
    function automatic logic [31:0] load_val(input logic [31:0] rdata, input int off, input logic [2:0] f3);
        int sz;
        logic [63:0] v;
        sz = size_of(f3);
        v = (64'(rdata) >> (8 * off)) % (64'd1 << (8 * sz));
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v - (64'd1 << (8 * sz));
        return v[31:0];
    endfunction

    function automatic logic [31:0] store_data(input logic [31:0] d, input int sz);
        if (sz == 1) return 32'(d[7:0]) * 32'h0101_0101;
        if (sz == 2) return 32'(d[15:0]) * 32'h0001_0001;
        return d;
    endfunction

    task automatic idle_inputs();
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0;
        hold = 1'b0; flush = 1'b0; dmem_ack = 1'b0;
    endtask

    // Issues one op at a negedge; returns at a negedge with the stage back in IDLE.
    task automatic run_op(input bit is_rd, input bit is_wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd,
                          input bit fl, input bit fl_busy, input int k, input logic [31:0] rdata);
        int sz, off, aoff, stalls;
        bit mem, trap, rw;
        logic [31:0] pc;
        logic [1:0] rs;
        pc = $urandom; rs = 2'($urandom_range(0, 3));
        mem = is_rd || is_wr;
        rw = is_rd || !mem;
        sz = size_of(f3);
        off = int'(addr % 4);
        aoff = off - (off % sz);
`ifdef MEM_MISALIGN_TRAP_EN
        trap = mem && (off % sz) != 0;
`else
        trap = 1'b0;
`endif
        ex_valid = 1'b1; ex_mem_read = is_rd; ex_mem_write = is_wr; ex_reg_write = rw;
        ex_funct3 = f3; ex_alu_res = addr; ex_store_data = sdata; ex_rd = rd;
        ex_pc_plus_4 = pc; ex_result_src = rs; flush = fl;
        @(posedge clk); #1;
        ex_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        if (fl) begin
            check_eq("flush_wb_valid", wb_valid, 0);
            check_eq("flush_req", dmem_req, 0);
            check_eq("flush_stall", stall_out, 0);
        end else if (!mem || trap) begin
            check_eq("wb_valid", wb_valid, 1);
            check_eq("wb_rd", wb_rd, rd);
            check_eq("wb_alu_res", wb_alu_res, addr);
            check_eq("wb_pc_plus_4", wb_pc_plus_4, pc);
            check_eq("wb_result_src", wb_result_src, rs);
            check_eq("wb_read_data", wb_read_data, 0);
            check_eq("wb_reg_write", wb_reg_write, trap ? 0 : rw);
            check_eq("wb_exc", wb_exc, trap);
            check_eq("idle_stall", stall_out, 0);
            check_eq("idle_req", dmem_req, 0);
        end else begin
            check_eq("req", dmem_req, 1);
            check_eq("we", dmem_we, is_wr);
            check_eq("addr", dmem_addr, addr - 32'(off - aoff));
            check_eq("be", dmem_be, ((1 << sz) - 1) << aoff);
            if (is_wr) check_eq("wdata", dmem_wdata, store_data(sdata, sz));
            check_eq("busy_wb_valid", wb_valid, 0);
            stalls = 0;
            for (int i = 1; i <= k; i++) begin
                if (stall_out) stalls++;
                if (i > 1) check_eq("req_held", dmem_req, 1);
                flush = fl_busy; hold = fl_busy;
                if (i == k) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = rdata;
                end
                @(posedge clk); #1;
                flush = 1'b0; hold = 1'b0; dmem_ack = 1'b0; dmem_rdata = $urandom;
                @(negedge clk);
            end
            check_eq("stall_cycles", stalls, k);
            check_eq("ack_wb_valid", wb_valid, 1);
            check_eq("ack_wb_rd", wb_rd, rd);
            check_eq("ack_wb_reg_write", wb_reg_write, rw);
            check_eq("ack_wb_alu_res", wb_alu_res, addr);
            check_eq("ack_wb_pc", wb_pc_plus_4, pc);
            check_eq("ack_read_data", wb_read_data, is_rd ? load_val(rdata, aoff, f3) : 32'd0);
            check_eq("ack_wb_exc", wb_exc, 0);
            check_eq("ack_stall", stall_out, 0);
            check_eq("ack_req", dmem_req, 0);
        end
    endtask

    initial begin
        idle_inputs();
        ex_alu_res = '0; ex_store_data = '0; ex_pc_plus_4 = '0; ex_rd = '0;
        ex_funct3 = '0; ex_result_src = '0; dmem_rdata = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_wb_valid", wb_valid, 0);
        check_eq("rst_req", dmem_req, 0);
        check_eq("rst_stall", stall_out, 0);
        check_eq("rst_be", dmem_be, 0);
        check_eq("rst_addr", dmem_addr, 0);
        check_eq("rst_wb_alu", wb_alu_res, 0);
        check_eq("rst_wb_exc", wb_exc, 0);

        // ALU op, then hold freezes WB
        run_op(0, 0, 3'b000, 32'h1234, 0, 5'd5, 0, 0, 1, 0);
        ex_valid = 1'b1; ex_alu_res = 32'h55; ex_rd = 5'd9; hold = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("hold_rd", wb_rd, 5);
        check_eq("hold_alu", wb_alu_res, 32'h1234);
        hold = 1'b0;
        @(posedge clk); #1 ex_valid = 1'b0;
        @(negedge clk);
        check_eq("unhold_rd", wb_rd, 9);

        // LB / LBU from byte 3
        run_op(1, 0, 3'b000, 32'h103, 0, 5'd7, 0, 0, 3, 32'h80FF_FF00);
        check_eq("lb_value", wb_read_data, 32'hFFFF_FF80);
        run_op(1, 0, 3'b100, 32'h103, 0, 5'd7, 0, 0, 3, 32'h80FF_FF00);
        check_eq("lbu_value", wb_read_data, 32'h0000_0080);
        // SH upper half
        run_op(0, 1, 3'b001, 32'h102, 32'h0000_ABCD, 5'd0, 0, 0, 2, 0);
        // flush in IDLE, then flush/hold during BUSY
        run_op(1, 0, 3'b010, 32'h200, 0, 5'd3, 1, 0, 1, 0);
        run_op(1, 0, 3'b010, 32'h200, 0, 5'd3, 0, 1, 3, 32'hDEAD_BEEF);
        // misaligned LW
        run_op(1, 0, 3'b010, 32'h101, 0, 5'd4, 0, 0, 1, 32'h1122_3344);

        // reset while BUSY
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_funct3 = 3'b010;
        ex_alu_res = 32'h300; ex_rd = 5'd6;
        @(posedge clk); #1 ex_valid = 1'b0;
        @(negedge clk);
        check_eq("pre_rst_req", dmem_req, 1);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_eq("midrst_req", dmem_req, 0);
        check_eq("midrst_stall", stall_out, 0);
        check_eq("midrst_wb_rd", wb_rd, 0);
        check_eq("midrst_wb_alu", wb_alu_res, 0);
        check_eq("midrst_wb_rdata", wb_read_data, 0);
        check_eq("midrst_wb_valid", wb_valid, 0);

        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = $urandom_range(0, 2);
            run_op(kind == 1, kind == 2,
                   (kind == 2) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7)),
                   $urandom & 32'hFFFF, $urandom, 5'($urandom), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 3) == 0), $urandom_range(1, 4), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
